// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: state encodings, oversampling
// constants and the s-counter width rule used when the stop period exceeds 16 ticks.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int START_MID  = 7;

  function automatic int s_width(input int sb_tick);
    return (sb_tick > 16) ? 5 : 4;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line and baud strobe in, parallel word and
// completion status out.
interface uart_rx_if #(parameter int DBIT = 8);
  logic            rx;
  logic            s_tick;
  logic [DBIT-1:0] dout;
  logic            rx_done_tick;
  logic            frame_err;

  modport master (output rx, s_tick, input dout, rx_done_tick, frame_err);
  modport slave  (input rx, s_tick, output dout, rx_done_tick, frame_err);
endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Two-stage synchronizer for asynchronous single-bit inputs; the reset value
// is a parameter so idle-high lines do not see a false edge out of reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampling, start-bit centre alignment, LSB-first data,
// stop-bit check, one-clock done pulse with registered word and framing error.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic     clk,
  input  logic     reset,
  uart_rx_if.slave rx_bus
);

  localparam int SW = s_width(SB_TICK);

  logic            w_rx_s;
  rx_state_t       r_state, w_state_nxt;
  logic [SW-1:0]   r_s, w_s_nxt;
  logic [2:0]      r_n, w_n_nxt;
  logic [DBIT-1:0] r_shreg, w_shreg_nxt;
  logic [DBIT-1:0] r_dout, w_dout_nxt;
  logic            r_done, w_done_nxt;
  logic            r_ferr, w_ferr_nxt;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (rx_bus.rx),
    .o_q   (w_rx_s)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_s     <= '0;
      r_n     <= '0;
      r_shreg <= '0;
      r_dout  <= '0;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_s     <= w_s_nxt;
      r_n     <= w_n_nxt;
      r_shreg <= w_shreg_nxt;
      r_dout  <= w_dout_nxt;
      r_done  <= w_done_nxt;
      r_ferr  <= w_ferr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_s_nxt     = r_s;
    w_n_nxt     = r_n;
    w_shreg_nxt = r_shreg;
    w_dout_nxt  = r_dout;
    w_done_nxt  = 1'b0;
    w_ferr_nxt  = r_ferr;
    case (r_state)
      ST_IDLE: begin
        if (!w_rx_s) begin
          w_state_nxt = ST_START;
          w_s_nxt     = '0;
        end
      end
      ST_START: begin
        if (rx_bus.s_tick) begin
          if (r_s == SW'(START_MID)) begin
            // Line must still be low at the bit centre, otherwise it was a glitch
            if (!w_rx_s) begin
              w_state_nxt = ST_DATA;
              w_s_nxt     = '0;
              w_n_nxt     = '0;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_s_nxt = r_s + SW'(1);
          end
        end
      end
      ST_DATA: begin
        if (rx_bus.s_tick) begin
          if (r_s == SW'(OVERSAMPLE - 1)) begin
            w_s_nxt     = '0;
            w_shreg_nxt = (r_shreg >> 1) | (DBIT'(w_rx_s) << (DBIT - 1));
            if (r_n == 3'(DBIT - 1)) begin
              w_state_nxt = ST_STOP;
            end else begin
              w_n_nxt = r_n + 3'd1;
            end
          end else begin
            w_s_nxt = r_s + SW'(1);
          end
        end
      end
      ST_STOP: begin
        if (rx_bus.s_tick) begin
          if (r_s == SW'(SB_TICK - 1)) begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
            w_dout_nxt  = r_shreg;
            w_ferr_nxt  = ~w_rx_s;
          end else begin
            w_s_nxt = r_s + SW'(1);
          end
        end
      end
    endcase
  end

  assign rx_bus.dout         = r_dout;
  assign rx_bus.rx_done_tick = r_done;
  assign rx_bus.frame_err    = r_ferr;

endmodule

// File: tb/tb_uart_rx.sv
// Randomized bench for uart_rx: a behavioural line driver feeds two receivers
// (1 and 2 stop bits); a queue-based scoreboard predicts every completed frame.
module tb_uart_rx;
  import uart_rx_pkg::*;

  logic clk = 1'b0;
  logic reset16 = 1'b1;
  logic reset32 = 1'b1;
  logic tick = 1'b0;
  logic rx16 = 1'b1;
  logic rx32 = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;
  int n_pulse16 = 0;
  int n_pulse32 = 0;
  int n_sent16 = 0;
  int n_sent32 = 0;
  logic [7:0] last16 = 8'h00;
  logic prev16 = 1'b0;
  logic prev32 = 1'b0;

  // expected frames: {frame_err, data}
  logic [8:0] exp16[$];
  logic [8:0] exp32[$];

  uart_rx_if #(.DBIT(8)) bus16 ();
  uart_rx_if #(.DBIT(8)) bus32 ();

  assign bus16.rx     = rx16;
  assign bus16.s_tick = tick;
  assign bus32.rx     = rx32;
  assign bus32.s_tick = tick;

  uart_rx #(.DBIT(8), .SB_TICK(16)) dut16 (.clk(clk), .reset(reset16), .rx_bus(bus16));
  uart_rx #(.DBIT(8), .SB_TICK(32)) dut32 (.clk(clk), .reset(reset32), .rx_bus(bus32));

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (3) @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!tick) @(posedge clk);
    end
    @(negedge clk);
  endtask

  task automatic set_rx(input int sel, input logic v);
    if (sel == 0) rx16 = v;
    else          rx32 = v;
  endtask

  task automatic send_frame(input int sel, input logic [7:0] data,
                            input logic stop_val, input int stop_ticks);
    if (sel == 0) begin exp16.push_back({~stop_val, data}); n_sent16++; end
    else          begin exp32.push_back({~stop_val, data}); n_sent32++; end
    set_rx(sel, 1'b0);
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      set_rx(sel, data[i]);
      wait_ticks(16);
    end
    set_rx(sel, stop_val);
    wait_ticks(stop_ticks);
    set_rx(sel, 1'b1);
  endtask

  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (prev16) chk("pulse_width16", bus16.rx_done_tick, 0);
      if (prev32) chk("pulse_width32", bus32.rx_done_tick, 0);
      if (bus16.rx_done_tick) begin
        n_pulse16++;
        if (exp16.size() == 0) chk("unexpected_done16", 1, 0);
        else begin
          e = exp16.pop_front();
          chk("dout16", bus16.dout, e[7:0]);
          chk("frame_err16", bus16.frame_err, e[8]);
          last16 = e[7:0];
        end
      end
      if (bus32.rx_done_tick) begin
        n_pulse32++;
        if (exp32.size() == 0) chk("unexpected_done32", 1, 0);
        else begin
          e = exp32.pop_front();
          chk("dout32", bus32.dout, e[7:0]);
          chk("frame_err32", bus32.frame_err, e[8]);
        end
      end
      prev16 = bus16.rx_done_tick;
      prev32 = bus32.rx_done_tick;
    end
  end

  initial begin
    int p0;
    int budget;
    repeat (4) @(negedge clk);
    chk("rst_dout16", bus16.dout, 0);
    chk("rst_done16", bus16.rx_done_tick, 0);
    chk("rst_ferr16", bus16.frame_err, 0);
    chk("rst_dout32", bus32.dout, 0);
    chk("rst_done32", bus32.rx_done_tick, 0);
    chk("rst_ferr32", bus32.frame_err, 0);
    reset16 = 1'b0;
    reset32 = 1'b0;
    repeat (4) @(negedge clk);

    fork
      begin
        send_frame(0, 8'hA5, 1'b1, 16);
        wait_ticks(20);

        for (int g = 0; g < 3; g++) begin
          p0 = n_pulse16;
          rx16 = 1'b0;
          wait_ticks($urandom_range(1, 5));
          rx16 = 1'b1;
          wait_ticks(30);
          chk("glitch_no_pulse", n_pulse16 - p0, 0);
          chk("glitch_dout_held", bus16.dout, last16);
        end

        // short low stop bit: sampled low, released before the re-armed start centre
        send_frame(0, 8'h3C, 1'b0, 12);
        wait_ticks(24);

        rx16 = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 3; i++) begin
          rx16 = 1'b1;
          wait_ticks(16);
        end
        rx16 = 1'b1;
        wait_ticks(8);
        reset16 = 1'b1;
        @(negedge clk);
        chk("midrst_dout", bus16.dout, 0);
        chk("midrst_done", bus16.rx_done_tick, 0);
        chk("midrst_ferr", bus16.frame_err, 0);
        wait_ticks(100);
        reset16 = 1'b0;
        last16 = 8'h00;
        wait_ticks(4);
        send_frame(0, 8'h5A, 1'b1, 16);
        wait_ticks(20);

        p0 = n_pulse16;
        send_frame(0, 8'h00, 1'b1, 16);
        send_frame(0, 8'hFF, 1'b1, 16);
        send_frame(0, 8'h81, 1'b1, 16);
        wait_ticks(20);
        chk("b2b_pulse_count", n_pulse16 - p0, 3);

        for (int r = 0; r < 16; r++) begin
          send_frame(0, 8'($urandom_range(0, 255)), 1'b1, 16);
          wait_ticks($urandom_range(0, 6));
        end
      end
      begin
        for (int v = 0; v < 256; v += 7) send_frame(1, 8'(v), 1'b1, 32);
        send_frame(1, 8'hFF, 1'b1, 32);
        for (int r = 0; r < 6; r++) send_frame(1, 8'($urandom_range(0, 255)), 1'b1, 32);
      end
    join

    budget = 2000;
    while ((exp16.size() != 0 || exp32.size() != 0) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    wait_ticks(20);
    chk("drain16", exp16.size(), 0);
    chk("drain32", exp32.size(), 0);
    chk("pulses16", n_pulse16, n_sent16);
    chk("pulses32", n_pulse32, n_sent32);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
